// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: single-port word-organised memory with byte-lane writes,
// configurable data-phase wait states and a two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSELx,
    input  logic                  HREADY,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int unsigned LANES = DATA_WIDTH / 8;
    localparam int unsigned OFFW  = $clog2(LANES);
    localparam int unsigned IDXW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned AW1   = ADDR_WIDTH + 1;

    localparam logic [2:0]      MAX_SIZE    = 3'(OFFW);
    localparam logic [AW1-1:0]  DEPTH_LIMIT = AW1'(MEM_DEPTH);
    localparam logic [3:0]      WAIT_LOAD   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic            write_q;
    logic [IDXW-1:0] index_q;
    logic [OFFW-1:0] offset_q;
    logic [OFFW-1:0] mask_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] addr_index;
    logic [OFFW-1:0]       addr_offset;
    logic [OFFW-1:0]       align_mask;
    logic                  range_err;
    logic                  size_err;
    logic                  align_err;
    logic                  addr_err;
    logic                  slave_ready;
    logic                  accept;
    logic                  complete;
    logic                  mem_we;
    logic [LANES-1:0]      lane_en;
    logic                  unused_inputs;

    assign unused_inputs = ^{HBURST, HTRANS[0]};

    // Address-phase decode
    assign addr_offset = HADDR[OFFW-1:0];
    assign addr_index  = HADDR >> OFFW;

    always_comb begin
        align_mask = '0;
        for (int i = 0; i < int'(OFFW); i++) begin
            align_mask[i] = (3'(i) < HSIZE);
        end
    end

    assign range_err = ({1'b0, addr_index} >= DEPTH_LIMIT);
    assign size_err  = (HSIZE > MAX_SIZE);
    assign align_err = |(addr_offset & align_mask);
    assign addr_err  = range_err | size_err | align_err;

    // Only IDLE and ERR2 drive HREADYOUT high, so only they can take a new address phase.
    assign slave_ready = (state_q == StIdle) || (state_q == StErr2);
    assign accept      = HSELx & HREADY & HTRANS[1] & slave_ready;

    // Every valid transfer completes in IDLE with pend_q set.
    assign complete = (state_q == StIdle) && pend_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = 1'b0;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;

        unique case (state_q)
            StIdle: begin
            end
            StWait: begin
                HREADYOUT = 1'b0;
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StIdle;
                    pend_d  = 1'b1;
                    cnt_d   = 4'd0;
                end
            end
            StErr1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_d   = StErr2;
            end
            StErr2: begin
                HRESP   = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            if (addr_err) begin
                state_d = StErr1;
                cnt_d   = 4'd0;
            end else if (WAIT_STATES > 0) begin
                state_d = StWait;
                cnt_d   = WAIT_LOAD;
            end else begin
                state_d = StIdle;
                pend_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            pend_q   <= 1'b0;
            write_q  <= 1'b0;
            index_q  <= '0;
            offset_q <= '0;
            mask_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            if (accept) begin
                write_q  <= HWRITE;
                index_q  <= addr_index[IDXW-1:0];
                offset_q <= addr_offset;
                mask_q   <= align_mask;
            end
        end
    end

    // Lanes of the naturally aligned block containing the latched offset.
    always_comb begin
        lane_en = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            lane_en[l] = ((OFFW'(l) & ~mask_q) == (offset_q & ~mask_q));
        end
    end

    // A reset arriving in the completion cycle must still drop the write.
    assign mem_we = complete && write_q && !HRESET;

    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int l = 0; l < int'(LANES); l++) begin
                if (lane_en[l]) begin
                    mem[index_q][8*l +: 8] <= HWDATA[8*l +: 8];
                end
            end
        end
    end

    assign HRDATA = (complete && !write_q) ? mem[index_q] : '0;

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

Parametrised AHB-Lite slave: single-port word-organised SRAM with configurable data width, depth and wait-state count; byte/halfword/word sizes with byte-lane writes and a two-cycle ERROR response. Sits behind the AHB decoder as a memory target on the `ahb_if` bus and is the generic endpoint for bench and SoC memory regions.

## Interface
- ADDR_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, HWDATA/HRDATA width; one of 32, 64, 128
- MEM_DEPTH, 1024, memory depth in DATA_WIDTH words
- WAIT_STATES, 0, extra data-phase cycles per valid transfer (0..15)
- HCLK  in  1  clock; all state on rising edge
- HRESET  in  1  reset, asynchronous, active-high
- HSELx  in  1  slave select from decoder
- HREADY  in  1  bus-level ready (previous transfer completing)
- HADDR  in  ADDR_WIDTH  byte address; slave decodes offset bits only
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- HWRITE  in  1  1=write
- HSIZE  in  3  transfer size, bytes = 1<<HSIZE
- HBURST  in  3  ignored; each beat handled independently
- HWDATA  in  DATA_WIDTH  write data, data phase
- HRDATA  out  DATA_WIDTH  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0=OKAY, 1=ERROR

## Operation
- Transfer accepted at rising edge when HSELx & HREADY & HTRANS[1]; latch HADDR, HSIZE, HWRITE. IDLE/BUSY or unselected: no latch, zero-wait OKAY.
- LANES = DATA_WIDTH/8; offset = HADDR[log2(LANES)-1:0]; index = HADDR >> log2(LANES).
- Error if any: index >= MEM_DEPTH; (8<<HSIZE) > DATA_WIDTH; offset not a multiple of 1<<HSIZE.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0. Accepted valid transfer -> WAIT if WAIT_STATES>0 (counter loaded WAIT_STATES), else stay IDLE with data phase completing next cycle. Accepted erroring transfer -> ERR1.
  - WAIT: HREADYOUT=0; counter decrements; at 1 -> completion cycle (HREADYOUT=1, OKAY), then IDLE or new transfer.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1 -> IDLE; transfer presented with HREADY=1 here is accepted normally.
- Write: in completion cycle, bytes at lanes offset..offset+(1<<HSIZE)-1 of HWDATA written to mem[index] at the closing edge; other lanes untouched. Little-endian.
- Read: HRDATA = mem[latched index] (full word, all lanes) in completion cycle; 0 at all other times.
- Errored transfers never modify memory; HRDATA=0.
- HMASTLOCK, HPROT, HNONSEC, HEXCL, HMASTER ignored.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, counter 0. Memory contents not reset.
- Valid transfer latency: data phase lasts 1+WAIT_STATES cycles.
- Error: exactly 2 data-phase cycles (ERR1, ERR2), regardless of WAIT_STATES.
- Back-to-back: next address phase overlaps completion cycle; write then read of same address with WAIT_STATES=0 returns new data (write commits on the same edge that latches the read).
- HRESET mid-transfer: immediate return to reset values; pending write dropped, memory unchanged.
- HSELx low during WAIT/ERR1: no effect; slave finishes its own data phase.

## Test plan
- Reset, WAIT_STATES=0: write word 0xDEADBEEF to 0x10, read 0x10 -> HRDATA=0xDEADBEEF, HREADYOUT=1 every cycle, HRESP=0.
- Byte write 0xAA (HSIZE=0) to 0x13 over word 0x11223344 -> read 0x10 returns 0xAA223344; halfword 0x5566 to 0x10 -> 0xAA225566.
- WAIT_STATES=3: single read -> HREADYOUT low 3 cycles then high with data; back-to-back NONSEQ/SEQ burst of 4 -> 16 data-phase cycles total.
- Address index = MEM_DEPTH, or HSIZE=1 at 0x01, or HSIZE=3 with DATA_WIDTH=32 -> HREADYOUT 0 then 1 with HRESP=1 both cycles; memory unchanged.
- IDLE and BUSY cycles with HSELx=1 -> no latch, OKAY zero-wait; HSELx=0 with NONSEQ -> ignored.
- HRESET asserted during WAIT of a write -> outputs at reset values next cycle, target word retains old value.
